// File: rtl/slot_pkg.sv
// Shared types and helpers for the slot_chaser lamp-chase game.
package slot_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    FLASH_ON  = 2'd2,
    FLASH_OFF = 2'd3
  } slot_state_e;

  localparam int MAX_LANES = 16;

  // Odd lanes lit: ...1010 across the widest supported lamp bank.
  function automatic logic [MAX_LANES-1:0] alt_pattern();
    logic [MAX_LANES-1:0] p;
    for (int k = 0; k < MAX_LANES; k++) begin
      p[k] = ((k % 2) == 1);
    end
    return p;
  endfunction

endpackage

// File: rtl/slot_tick_gen.sv
// Free-running divider; tick is high for one clock every 2^DIV_W clocks.
module slot_tick_gen #(
  parameter int DIV_W = 24
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = &cnt_q;

endmodule

// File: rtl/slot_chaser.sv
// Lamp chase across N lanes; a press on the lit lane scores, speeds up play
// and triggers a bounded win flash. Presses are latched between ticks.
//
//   state     | meaning
//   ----------+---------------------------------------------------
//   IDLE      | attract pattern ...1010, waiting for first tick
//   RUN       | one lamp chasing; presses judged on each tick
//   FLASH_ON  | win flash, all lamps lit
//   FLASH_OFF | win flash, all lamps dark
module slot_chaser
  import slot_pkg::*;
#(
  parameter int N             = 4,
  parameter int DIV_W         = 24,
  parameter int START_STEP    = 4,
  parameter int MIN_STEP      = 1,
  parameter int FLASH_TOGGLES = 8,
  parameter int BOUNCE        = 0,
  parameter int SCORE_W       = 8
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic [N-1:0]       SWITCHES,
  output logic [N-1:0]       LEDS,
  output logic [SCORE_W-1:0] SCORE,
  output logic               WIN,
  output logic               MISS
);

  localparam int POS_W = $clog2(N);
  localparam int CNT_W = $clog2(START_STEP + 1);
  localparam int FL_W  = $clog2(FLASH_TOGGLES + 1);

  localparam logic [CNT_W-1:0]     START_P  = CNT_W'(START_STEP);
  localparam logic [CNT_W-1:0]     MIN_P    = CNT_W'(MIN_STEP);
  localparam logic [FL_W-1:0]      FL_LAST  = FL_W'(FLASH_TOGGLES - 1);
  localparam logic [POS_W-1:0]     POS_LAST = POS_W'(N - 1);
  localparam logic [MAX_LANES-1:0] ALT_FULL = alt_pattern();
  localparam logic [N-1:0]         ALT      = ALT_FULL[N-1:0];

  logic tick;

  slot_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk  (CLOCK),
    .rst  (RESET),
    .tick (tick)
  );

  logic [N-1:0] rise;

  for (genvar k = 0; k < N; k++) begin : g_sync
    logic s1_q, s2_q, prev_q;

    always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
        s1_q   <= 1'b0;
        s2_q   <= 1'b0;
        prev_q <= 1'b0;
      end else begin
        s1_q   <= SWITCHES[k];
        s2_q   <= s1_q;
        prev_q <= s2_q;
      end
    end

    assign rise[k] = s2_q & ~prev_q;
  end

  slot_state_e        state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               dir_up_q, dir_up_d;
  logic [CNT_W-1:0]   step_q, step_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [FL_W-1:0]    flash_q, flash_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [N-1:0]       pend_q, pend_d;
  logic [N-1:0]       leds_q, leds_d;
  logic               win_q, win_d;
  logic               miss_q, miss_d;

  logic [N-1:0]     lane_sel;
  logic             lane_hit;
  logic             lane_miss;
  logic [POS_W-1:0] adv_pos;
  logic             adv_dir_up;

  always_comb begin
    lane_sel  = N'(1) << pos_q;
    lane_hit  = |(pend_q & lane_sel);
    lane_miss = |(pend_q & ~lane_sel);

    adv_pos    = pos_q;
    adv_dir_up = dir_up_q;
    if (BOUNCE == 0) begin
      adv_pos = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
    end else if (dir_up_q) begin
      // Direction flips on arrival at an end so the end lane is shown once.
      adv_pos    = pos_q + POS_W'(1);
      adv_dir_up = (adv_pos != POS_LAST);
    end else begin
      adv_pos    = pos_q - POS_W'(1);
      adv_dir_up = (adv_pos == '0);
    end
  end

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    dir_up_d = dir_up_q;
    step_d   = step_q;
    period_d = period_q;
    flash_d  = flash_q;
    score_d  = score_q;
    win_d    = 1'b0;
    miss_d   = 1'b0;
    // An edge arriving on the tick cycle belongs to the next window.
    pend_d   = tick ? rise : (pend_q | rise);

    if (tick) begin
      unique case (state_q)
        IDLE: begin
          state_d  = RUN;
          pos_d    = '0;
          dir_up_d = 1'b1;
          step_d   = '0;
        end
        RUN: begin
          if (lane_hit) begin
            state_d  = FLASH_ON;
            flash_d  = '0;
            win_d    = 1'b1;
            score_d  = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
            period_d = (period_q > MIN_P) ? period_q - CNT_W'(1) : MIN_P;
          end else if (lane_miss) begin
            miss_d   = 1'b1;
            period_d = START_P;
            step_d   = '0;
          end else if (step_q == period_q - CNT_W'(1)) begin
            step_d   = '0;
            pos_d    = adv_pos;
            dir_up_d = adv_dir_up;
          end else begin
            step_d   = step_q + CNT_W'(1);
          end
        end
        FLASH_ON, FLASH_OFF: begin
          if (flash_q == FL_LAST) begin
            state_d  = RUN;
            flash_d  = '0;
            pos_d    = '0;
            dir_up_d = 1'b1;
            step_d   = '0;
          end else begin
            flash_d  = flash_q + FL_W'(1);
            state_d  = (state_q == FLASH_ON) ? FLASH_OFF : FLASH_ON;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    unique case (state_d)
      IDLE:     leds_d = ALT;
      RUN:      leds_d = N'(1) << pos_d;
      FLASH_ON: leds_d = '1;
      default:  leds_d = '0;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      pos_q    <= '0;
      dir_up_q <= 1'b1;
      step_q   <= '0;
      period_q <= START_P;
      flash_q  <= '0;
      score_q  <= '0;
      pend_q   <= '0;
      leds_q   <= ALT;
      win_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      dir_up_q <= dir_up_d;
      step_q   <= step_d;
      period_q <= period_d;
      flash_q  <= flash_d;
      score_q  <= score_d;
      pend_q   <= pend_d;
      leds_q   <= leds_d;
      win_q    <= win_d;
      miss_q   <= miss_d;
    end
  end

  assign LEDS  = leds_q;
  assign SCORE = score_q;
  assign WIN   = win_q;
  assign MISS  = miss_q;

endmodule

// File: tb/tb_slot_chaser.sv
// Scoreboard bench for slot_chaser: wrap and ping-pong instances share stimulus,
// a behavioural game model predicts every output change and its cycle.
module tb_slot_chaser;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] SWITCHES = 4'b0000;

  logic [3:0] leds_a, leds_b;
  logic [1:0] score_a, score_b;
  logic       win_a, win_b, miss_a, miss_b;

  slot_chaser #(.N(4), .DIV_W(2), .START_STEP(2), .MIN_STEP(1), .FLASH_TOGGLES(4),
                .BOUNCE(0), .SCORE_W(2)) u_wrap (
    .CLOCK(CLOCK), .RESET(RESET), .SWITCHES(SWITCHES),
    .LEDS(leds_a), .SCORE(score_a), .WIN(win_a), .MISS(miss_a));

  slot_chaser #(.N(4), .DIV_W(2), .START_STEP(2), .MIN_STEP(1), .FLASH_TOGGLES(4),
                .BOUNCE(1), .SCORE_W(2)) u_bounce (
    .CLOCK(CLOCK), .RESET(RESET), .SWITCHES(SWITCHES),
    .LEDS(leds_b), .SCORE(score_b), .WIN(win_b), .MISS(miss_b));

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    int         cyc;
    logic [7:0] v;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // ---------------- behavioural model ----------------
  localparam int S_IDLE = 0, S_RUN = 1, S_FON = 2, S_FOFF = 3;

  int         m_tcnt;
  bit         m_tick;
  logic [3:0] h0, h1, h2, m_pend;
  int         m_st[2], m_pos[2], m_dir[2], m_step[2], m_per[2], m_fl[2], m_score[2];
  bit         m_win[2], m_miss[2];
  bit         m_bounce[2] = '{1'b0, 1'b1};
  logic [7:0] m_prev[2];
  bit         m_first = 1'b1;

  function automatic logic [7:0] m_tuple(input int i);
    logic [3:0] l;
    case (m_st[i])
      S_IDLE:  l = 4'b1010;
      S_RUN:   l = 4'(1 << m_pos[i]);
      S_FON:   l = 4'b1111;
      default: l = 4'b0000;
    endcase
    return {l, m_win[i], m_miss[i], 2'(m_score[i])};
  endfunction

  task automatic m_reset();
    m_tcnt = 0; m_tick = 1'b0; m_pend = '0;
    h0 = '0; h1 = '0; h2 = '0;
    for (int i = 0; i < 2; i++) begin
      m_st[i] = S_IDLE; m_pos[i] = 0; m_dir[i] = 1; m_step[i] = 0;
      m_per[i] = 2; m_fl[i] = 0; m_score[i] = 0; m_win[i] = 0; m_miss[i] = 0;
    end
  endtask

  task automatic m_decide(input int i, input logic [3:0] pend);
    case (m_st[i])
      S_IDLE: begin
        m_st[i] = S_RUN; m_pos[i] = 0; m_dir[i] = 1; m_step[i] = 0;
      end
      S_RUN: begin
        if (pend[m_pos[i]]) begin
          m_st[i] = S_FON; m_fl[i] = 0; m_win[i] = 1;
          m_score[i] = (m_score[i] < 3) ? m_score[i] + 1 : 3;
          m_per[i] = (m_per[i] > 1) ? m_per[i] - 1 : 1;
        end else if (pend != 0) begin
          m_miss[i] = 1; m_per[i] = 2; m_step[i] = 0;
        end else if (m_step[i] == m_per[i] - 1) begin
          m_step[i] = 0;
          if (!m_bounce[i]) m_pos[i] = (m_pos[i] + 1) % 4;
          else begin
            if (m_pos[i] + m_dir[i] < 0 || m_pos[i] + m_dir[i] > 3) m_dir[i] = -m_dir[i];
            m_pos[i] = m_pos[i] + m_dir[i];
          end
        end else begin
          m_step[i]++;
        end
      end
      default: begin
        m_fl[i]++;
        if (m_fl[i] == 4) begin
          m_st[i] = S_RUN; m_pos[i] = 0; m_dir[i] = 1; m_step[i] = 0;
        end else begin
          m_st[i] = (m_st[i] == S_FON) ? S_FOFF : S_FON;
        end
      end
    endcase
  endtask

  always @(posedge CLOCK) begin
    logic [3:0] arr;
    logic [7:0] t;
    exp_t       e;
    cyc++;
    if (RESET) begin
      m_reset();
    end else begin
      m_tick = (m_tcnt == 3);
      m_tcnt = (m_tcnt + 1) % 4;
      arr = h1 & ~h2;
      for (int i = 0; i < 2; i++) begin
        m_win[i] = 0; m_miss[i] = 0;
        if (m_tick) m_decide(i, m_pend);
      end
      m_pend = m_tick ? arr : (m_pend | arr);
      h2 = h1; h1 = h0; h0 = SWITCHES;
    end
    for (int i = 0; i < 2; i++) begin
      t = m_tuple(i);
      if (m_first || t !== m_prev[i]) begin
        e.cyc = cyc; e.v = t;
        if (i == 0) q_a.push_back(e); else q_b.push_back(e);
      end
      m_prev[i] = t;
    end
    m_first = 1'b0;
  end

  // ---------------- monitor ----------------
  logic [7:0] prv_a = 'x, prv_b = 'x, cur_a, cur_b;

  task automatic mon(input int id, input logic [7:0] cur);
    exp_t  e;
    bit    empty;
    string nm;
    nm = (id == 0) ? "wrap" : "bounce";
    empty = (id == 0) ? (q_a.size() == 0) : (q_b.size() == 0);
    checks++;
    if (empty) begin
      errors++;
      $display("FAIL %s unexpected output change at cyc %0d: got leds/win/miss/score=%b", nm, cyc, cur);
    end else begin
      if (id == 0) e = q_a.pop_front(); else e = q_b.pop_front();
      if (e.v !== cur || e.cyc != cyc) begin
        errors++;
        $display("FAIL %s outputs: got %b at cyc %0d, expected %b at cyc %0d", nm, cur, cyc, e.v, e.cyc);
      end
    end
  endtask

  always @(posedge CLOCK) begin
    #3;
    cur_a = {leds_a, win_a, miss_a, score_a};
    cur_b = {leds_b, win_b, miss_b, score_b};
    if (cur_a !== prv_a) begin mon(0, cur_a); prv_a = cur_a; end
    if (cur_b !== prv_b) begin mon(1, cur_b); prv_b = cur_b; end
  end

  // ---------------- stimulus ----------------
  task automatic pulse(input logic [3:0] m, input int len);
    @(negedge CLOCK);
    SWITCHES = m;
    repeat (len) @(negedge CLOCK);
    SWITCHES = 4'b0000;
  endtask

  task automatic wait_run();
    for (int k = 0; k < 64; k++) begin
      if (m_st[0] == S_RUN) break;
      @(posedge CLOCK); #1;
    end
  endtask

  task automatic wait_tick();
    for (int k = 0; k < 8; k++) begin
      @(posedge CLOCK); #1;
      if (m_tick) break;
    end
  endtask

  task automatic hit_a();
    wait_run();
    wait_tick();
    pulse(4'(1 << m_pos[0]), 1);
  endtask

  initial begin
    RESET = 1'b1;
    repeat (3) @(negedge CLOCK);
    RESET = 1'b0;
    repeat (48) @(negedge CLOCK);

    hit_a();
    repeat (40) @(negedge CLOCK);

    wait_run();
    wait_tick();
    pulse(4'(1 << ((m_pos[0] + 2) % 4)), 1);
    repeat (24) @(negedge CLOCK);

    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 3))
        0: hit_a();
        1: pulse(4'($urandom_range(1, 15)), $urandom_range(1, 3));
        2: repeat ($urandom_range(1, 6)) @(negedge CLOCK);
        default: pulse(4'(1 << $urandom_range(0, 3)), 1);
      endcase
    end
    repeat (30) @(negedge CLOCK);

    repeat (5) hit_a();
    repeat (30) @(negedge CLOCK);

    hit_a();
    for (int k = 0; k < 20; k++) begin
      if (m_st[0] == S_FON) break;
      @(posedge CLOCK); #1;
    end
    @(negedge CLOCK); RESET = 1'b1;
    @(negedge CLOCK); RESET = 1'b0;
    repeat (40) @(negedge CLOCK);

    checks++;
    if (q_a.size() != 0) begin
      errors++;
      $display("FAIL wrap drain: %0d expected changes never seen, required 0", q_a.size());
    end
    checks++;
    if (q_b.size() != 0) begin
      errors++;
      $display("FAIL bounce drain: %0d expected changes never seen, required 0", q_b.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slot_chaser.md
# slot_chaser

Parametrised successor to the four-lamp jackpot game. One lamp chases across `N` lanes at a tick-derived rate. A switch press on the lit lane scores a hit, speeds the chase up and plays a bounded win flash. Presses are synchronised and held between ticks, so a press is never lost, and the chase runs in wrap or ping-pong mode. Sits at top level between the board switches/LEDs and an optional score display.

## Interface
- `N`, 4: lane count (LEDs and switches); legal range 2..16.
- `DIV_W`, 24: tick divider width; one tick every 2^DIV_W clocks.
- `START_STEP`, 4: ticks per lane step after reset or a miss; must be ≥1.
- `MIN_STEP`, 1: fastest step period in ticks; 1 ≤ MIN_STEP ≤ START_STEP.
- `FLASH_TOGGLES`, 8: flash half-periods (each one tick) before play resumes; must be ≥1.
- `BOUNCE`, 0: 0 = wrap N-1→0; 1 = ping-pong.
- `SCORE_W`, 8: score width.

Ports:
- `CLOCK`  in  1  sole clock.
- `RESET`  in  1  asynchronous, active-high reset.
- `SWITCHES`  in  N  raw asynchronous player switches.
- `LEDS`  out  N  lamp outputs.
- `SCORE`  out  SCORE_W  hit count; saturates at all-ones.
- `WIN`  out  1  one-CLOCK pulse on each hit.
- `MISS`  out  1  one-CLOCK pulse on each wrong-lane press.

## Operation
- Each switch passes through a 2-flop synchroniser and a rising-edge detector in the CLOCK domain.
- A detected edge sets `pend[k]`. `pend` holds until the next tick cycle, then clears on that cycle.
  - An edge on the tick cycle itself is not lost. It lands in the next window.
- States: IDLE, RUN, FLASH_ON, FLASH_OFF. All state, position and counter updates happen only on tick cycles.
- **IDLE**
  - LEDS = alternating pattern, lane 1, 3, 5… lit (…1010).
  - Next tick → RUN with pos=0, dir=up, step_cnt=0.
- **RUN**
  - LEDS = one-hot(pos).
  - On each tick, evaluate in priority order:
    1. **Hit**: `pend[pos]`=1. Go to FLASH_ON. SCORE+1 (saturating). WIN=1. period = max(period-1, MIN_STEP).
    2. **Miss**: any other `pend` bit set. MISS=1. period = START_STEP. pos does not move this tick. step_cnt=0.
    3. **Step**: neither hit nor miss, and step_cnt == period-1. step_cnt=0 and pos advances.
    4. **Count**: otherwise step_cnt+1.
  - A simultaneous hit and wrong-lane press counts as a hit only.
- **Advance rule**
  - BOUNCE=0: pos+1, wrapping N-1→0.
  - BOUNCE=1: move in dir. At lane N-1 dir flips to down; at lane 0 it flips to up. The end lane is not repeated (…N-2, N-1, N-2…).
- **FLASH_ON / FLASH_OFF**
  - LEDS = all-ones / all-zeros.
  - The states alternate each tick. flash_cnt counts toggles.
  - After FLASH_TOGGLES toggles → RUN with pos=0, dir=up, step_cnt=0.
  - `pend` clears every tick during flash. Presses during flash are ignored and are neither hit nor miss.
- The new period takes effect on the first step after flash.

## Timing
- Reset values: state=IDLE, LEDS=alternating pattern, SCORE=0, WIN=0, MISS=0, period=START_STEP, pos=0, dir=up, all counters and `pend` = 0. Synchroniser flops reset to 0.
- Switch edge → `pend` set: 3 CLOCK cycles (2 synchroniser stages + edge detect).
- `pend` → decision: at the next tick. WIN, MISS and LEDS update on the clock edge that ends the tick cycle.
- RESET asserted mid-flash or mid-run returns the block to IDLE at once. No WIN or MISS pulse is produced.
- A switch held high produces one edge only. A release and re-press is a new edge.

## Structure
- Shared package `slot_pkg`:
  - state enum constants (IDLE, RUN, FLASH_ON, FLASH_OFF);
  - alternating-pattern generator function.
- Sub-module `slot_tick_gen` (parameter DIV_W): free-running counter with a one-cycle `tick` output when all-ones. Reset is asynchronous.
- Synchronisers and edge detectors are a generate loop inside `slot_chaser`.

## Test plan
All scenarios use DIV_W=2 (tick every 4 clocks), N=4, START_STEP=2, MIN_STEP=1, FLASH_TOGGLES=4.
- **Reset/idle**: release RESET → LEDS=1010 until the first tick, then 0001. Lamp advances every 2 ticks: 0010, 0100, 1000, 0001.
- **Hit**: pulse SWITCHES[pos] while lit → WIN pulse, SCORE=1. LEDS goes 1111/0000 for 4 ticks, then 0001. Steps now occur every tick.
- **Miss**: press SWITCHES[2] while LEDS=0001 → MISS pulse, SCORE unchanged, lamp holds one extra tick, period back to 2.
- **Press between ticks**: 1-clock switch pulse just after a tick → hit still registered at the next tick. Pulse on the tick cycle → counted in the following window.
- **BOUNCE=1**: lamp sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001. Score saturation: SCORE_W=2 with 5 hits → SCORE=3.
- **Reset mid-flash**: assert RESET during FLASH_ON → LEDS=1010 and SCORE=0 immediately, with no WIN pulse.
